// File: rtl/key_code_validator_if.sv
// Purpose: bundles the key-entry inputs and the validator's result outputs.
// Ports:   key_valid/key_code/listo driven by the keypad side (master);
//          validat/validap/validab/error/locked/stage/digit_cnt driven by the validator (slave).
interface key_code_validator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       listo;
  logic       validat;
  logic       validap;
  logic       validab;
  logic       error;
  logic       locked;
  logic [1:0] stage;
  logic [2:0] digit_cnt;

  modport master (
    output key_valid, key_code, listo,
    input  validat, validap, validab, error, locked, stage, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, listo,
    output validat, validap, validab, error, locked, stage, digit_cnt
  );
endinterface

// File: rtl/key_code_validator.sv
// Purpose: collects 4-digit keypad codes, checks them against three staged codes
//          (T, P, B) and locks out the keypad after MAX_FAIL consecutive mismatches.
// Ports:   clk, reset (sync, active-high); bus (slave): key_valid/key_code/listo in,
//          validat/validap/validab/error pulses, locked level, stage, digit_cnt out.
module key_code_validator #(
  parameter logic [15:0] CODE_T      = 16'h1234,
  parameter logic [15:0] CODE_P      = 16'h5678,
  parameter logic [15:0] CODE_B      = 16'h9012,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  reset,
  key_code_validator_if.slave  bus
);

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPARE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] buffer;
  logic [2:0]  digit_cnt_q;
  logic [1:0]  stage_q;
  logic [3:0]  fail_cnt;
  logic [15:0] lock_cnt;
  logic        locked_q;
  // Pulse bit order: {error, validab, validap, validat}.
  logic [3:0]  pulse_next, pulse_d, pulse_q;

  logic [15:0] stage_code;
  logic        key_is_digit;
  logic        match;
  logic        fail_limit;
  logic        lock_done;

  always_comb begin
    case (stage_q)
      2'd0:    stage_code = CODE_T;
      2'd1:    stage_code = CODE_P;
      2'd2:    stage_code = CODE_B;
      default: stage_code = '0;
    endcase
  end

  assign key_is_digit = (bus.key_code <= 4'd9);
  assign match        = (digit_cnt_q == 3'd4) && (stage_q != 2'd3) && (buffer == stage_code);
  // Widened by one bit so MAX_FAIL=15 cannot wrap the comparison.
  assign fail_limit   = (({1'b0, fail_cnt} + 5'd1) >= 5'(MAX_FAIL));
  // Counter holding 1 means this edge brings it to zero and ends the lockout.
  assign lock_done    = (lock_cnt <= 16'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Next-state logic; listo masks any coincident key.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (bus.key_valid && !bus.listo && (bus.key_code == KEY_ENTER) && (stage_q != 2'd3))
          state_next = COMPARE;
      end
      COMPARE: begin
        if (match)           state_next = COLLECT;
        else if (fail_limit) state_next = LOCKED;
        else                 state_next = COLLECT;
      end
      LOCKED: begin
        if (lock_done) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Output logic: result of the single COMPARE cycle.
  always_comb begin
    pulse_next = '0;
    if (state == COMPARE) begin
      if (match) begin
        case (stage_q)
          2'd0:    pulse_next[0] = 1'b1;
          2'd1:    pulse_next[1] = 1'b1;
          default: pulse_next[2] = 1'b1;
        endcase
      end else begin
        pulse_next[3] = 1'b1;
      end
    end
  end

  // Datapath and registered outputs. The pulse goes through two registers so it
  // appears two edges after the edge that sampled enter.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer      <= '0;
      digit_cnt_q <= '0;
      stage_q     <= '0;
      fail_cnt    <= '0;
      lock_cnt    <= '0;
      locked_q    <= 1'b0;
      pulse_d     <= '0;
      pulse_q     <= '0;
    end else begin
      pulse_d  <= pulse_next;
      pulse_q  <= pulse_d;
      locked_q <= (state_next == LOCKED);
      case (state)
        COLLECT: begin
          if (bus.listo) begin
            buffer      <= '0;
            digit_cnt_q <= '0;
            stage_q     <= '0;
          end else if (bus.key_valid) begin
            if (key_is_digit && (digit_cnt_q < 3'd4)) begin
              buffer      <= {buffer[11:0], bus.key_code};
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end else if (bus.key_code == KEY_CLEAR) begin
              buffer      <= '0;
              digit_cnt_q <= '0;
            end
          end
        end
        COMPARE: begin
          buffer      <= '0;
          digit_cnt_q <= '0;
          if (match) begin
            fail_cnt <= '0;
            if (stage_q != 2'd3) stage_q <= stage_q + 2'd1;
          end else begin
            fail_cnt <= fail_cnt + 4'd1;
            if (fail_limit) lock_cnt <= 16'(LOCK_CYCLES);
          end
          // listo still lets the compare result out but rewinds the stage.
          if (bus.listo) stage_q <= '0;
        end
        LOCKED: begin
          lock_cnt <= lock_cnt - 16'd1;
          if (lock_done) fail_cnt <= '0;
          if (bus.listo) begin
            buffer      <= '0;
            digit_cnt_q <= '0;
            stage_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.validat   = pulse_q[0];
  assign bus.validap   = pulse_q[1];
  assign bus.validab   = pulse_q[2];
  assign bus.error     = pulse_q[3];
  assign bus.locked    = locked_q;
  assign bus.stage     = stage_q;
  assign bus.digit_cnt = digit_cnt_q;

endmodule

// File: doc/key_code_validator.md
KEY_CODE_VALIDATOR -- requirements
Module: key_code_validator

Interface
REQ-001 The block SHALL have parameter CODE_T, 16'h1234, 4-digit code for stage 0; a match generates validat.
REQ-002 The block SHALL have parameter CODE_P, 16'h5678, 4-digit code for stage 1; a match generates validap.
REQ-003 The block SHALL have parameter CODE_B, 16'h9012, 4-digit code for stage 2; a match generates validab.
REQ-004 The block SHALL have parameter MAX_FAIL, 3, number of consecutive mismatches that triggers lockout (range 1-15).
REQ-005 The block SHALL have parameter LOCK_CYCLES, 1000, lockout duration in clk cycles (range 1 to 2^16-1).
REQ-006 Port clk, input, 1, clock; all logic is on the rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port key_valid, input, 1, single-cycle strobe qualifying key_code.
REQ-009 Port key_code, input, 4, 0-9 digit, 4'hC clear, 4'hE enter; other values are ignored.
REQ-010 Port listo, input, 1, sequence-complete pulse from the downstream sequencer.
REQ-011 Port validat / validap / validab, output, 1 each, one-cycle match pulses to the downstream sequencer.
REQ-012 Port error, output, 1, one-cycle mismatch pulse.
REQ-013 Port locked, output, 1, level; high during lockout.
REQ-014 Port stage, output, 2, current expected code: 0=T, 1=P, 2=B, 3=DONE.
REQ-015 Port digit_cnt, output, 3, number of digits buffered (0-4).

Function
REQ-016 The FSM SHALL have states COLLECT, COMPARE and LOCKED, and all outputs SHALL be registered.
REQ-017 In COLLECT, a digit key with digit_cnt<4 SHALL be accepted: buffer <= {buffer[11:0], key_code} and digit_cnt increments.
REQ-018 A digit key with digit_cnt==4 SHALL be dropped, leaving the buffer and count unchanged.
REQ-019 Clear key in COLLECT SHALL zero the buffer and digit_cnt without touching stage or the fail counter.
REQ-020 Enter key in COLLECT with stage<3 SHALL move the FSM to COMPARE; enter with stage==3 SHALL be ignored.
REQ-021 COMPARE SHALL last exactly one cycle and declare a match only when digit_cnt==4 and buffer equals the code selected by stage.
REQ-022 On a match, the valid pulse for the current stage SHALL go high for exactly one cycle, starting 2 clock edges after the edge that sampled enter.
REQ-023 On a match, stage SHALL increment (saturating at 3), the fail counter SHALL clear, and the buffer and digit_cnt SHALL clear; the FSM SHALL then return to COLLECT.
REQ-024 On a mismatch, including enter with digit_cnt<4, error SHALL pulse for one cycle with the same timing as REQ-022, the fail counter SHALL increment, and the buffer and digit_cnt SHALL clear.
REQ-025 On a mismatch, the FSM SHALL go to LOCKED if the fail counter reaches MAX_FAIL; otherwise it SHALL go to COLLECT.
REQ-026 In LOCKED, locked SHALL be 1, all keys SHALL be ignored, and a down-counter SHALL be loaded with LOCK_CYCLES.
REQ-027 When the LOCKED counter reaches 0, the FSM SHALL clear the fail counter and return to COLLECT; locked SHALL fall on that same edge.
REQ-028 Keys arriving during COMPARE or LOCKED SHALL be dropped, not queued.
REQ-029 listo SHALL set stage to 0 and clear the buffer and digit_cnt in any state, without shortening an active lockout.
REQ-030 If listo and key_valid coincide, listo SHALL win and the key SHALL be dropped.
REQ-031 If listo coincides with a COMPARE cycle, the compare result pulse SHALL still be emitted and stage SHALL become 0.
REQ-032 At most one of validat, validap, validab and error SHALL be high in any cycle.

Reset
REQ-033 While reset is high at a clock edge, the FSM SHALL enter COLLECT, and the buffer, digit_cnt, stage, fail counter and lock counter SHALL all be 0.
REQ-034 While reset is high at a clock edge, all pulse outputs and locked SHALL be 0.
REQ-035 Reset SHALL take precedence over listo and key_valid.
REQ-036 Reset mid-lockout SHALL end the lockout immediately.

Verification
REQ-037 Keys 1,2,3,4,E -> validat high for 1 cycle, 2 edges after E is sampled; stage=1; digit_cnt=0.
REQ-038 Full run of 1234E, 5678E, 9012E -> validat, validap and validab pulse in order; stage=3; a further E produces no pulse.
REQ-039 At stage 0, keys 1,2,3,E -> error pulse; then 1,2,3,4,5,E -> validat (the fifth digit is dropped).
REQ-040 Three wrong entries with MAX_FAIL=3 and LOCK_CYCLES=10 -> locked=1 for 10 cycles and keys are ignored; then 1234E -> validat.
REQ-041 listo asserted with key_valid in the same cycle, at stage 2 with 2 digits buffered -> stage=0, digit_cnt=0, and the key is not recorded.
REQ-042 reset pulsed during LOCKED -> locked=0, stage=0 next cycle; 1234E is accepted immediately.
